// File: rtl/image_ram_writer_pkg.sv
// Shared definitions for the 64x64 monochrome image path: opcodes, FSM
// encoding and image geometry used by both the writer and the scan stage.
package image_ram_writer_pkg;

  localparam int IMG_ADDR_W = 12;
  localparam int IMG_X_W    = 6;

  typedef enum logic [1:0] {
    OP_PIXEL  = 2'b00,
    OP_FILL   = 2'b01,
    OP_WORD   = 2'b10,
    OP_STATUS = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_WORD = 2'b10
  } state_t;

  // Opcode lives in the top two bits of the Nios dataa operand.
  function automatic opcode_t cmd_op(input logic [31:0] dataa);
    return opcode_t'(dataa[31:30]);
  endfunction

endpackage

// File: rtl/image_ram_writer_if.sv
// Nios custom-instruction handshake plus image RAM write port, bundled so the
// CPU side (master) and the writer (slave) share one connection.
interface image_ram_writer_if
  import image_ram_writer_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W
) ();

  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic              start;
  logic              clk_en;
  logic [31:0]       result;
  logic              done;
  logic [ADDR_W-1:0] wraddress;
  logic              data;
  logic              wren;

  modport master (
    output dataa, datab, start, clk_en,
    input  result, done, wraddress, data, wren
  );

  modport slave (
    input  dataa, datab, start, clk_en,
    output result, done, wraddress, data, wren
  );

endinterface

// File: rtl/image_ram_writer.sv
// Nios custom instruction that writes 1-bit pixels into the image RAM write
// port: single pixel, 32-pixel word, full-frame fill and write-count status.
module image_ram_writer
  import image_ram_writer_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int X_W    = IMG_X_W
) (
  input  logic               clk,
  input  logic               reset,
  image_ram_writer_if.slave  io_nios
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            r_state;
  state_t            w_next_state;

  logic [ADDR_W-1:0] r_idx;
  logic [4:0]        r_bit;
  logic [31:0]       r_payload;
  logic              r_blk;
  logic [31:0]       r_count;

  logic [31:0]       r_result;
  logic              r_done;
  logic [ADDR_W-1:0] r_wraddr;
  logic              r_data;
  logic              r_wren;

  opcode_t                 w_op;
  logic [ADDR_W-X_W-1:0]   w_y;
  logic [X_W-1:0]          w_x;
  logic [ADDR_W-1:0]       w_cmd_addr;
  logic                    w_accept;
  logic                    w_unused_dataa;

  logic              w_wren;
  logic              w_data;
  logic [ADDR_W-1:0] w_addr;
  logic              w_done;
  logic [31:0]       w_result;
  logic [ADDR_W-1:0] w_idx_n;
  logic [4:0]        w_bit_n;
  logic [31:0]       w_payload_n;
  logic              w_blk;

  function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:5], 5'b0};
  endfunction

  assign w_op           = cmd_op(io_nios.dataa);
  assign w_y            = io_nios.dataa[ADDR_W-1:X_W];
  assign w_x            = io_nios.dataa[X_W-1:0];
  assign w_cmd_addr     = {w_y, w_x};
  assign w_unused_dataa = &{1'b0, io_nios.dataa[29:ADDR_W]};

  // A start seen during the done cycle of FILL/WORD must not launch a command.
  assign w_accept = io_nios.start & ~r_blk;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (io_nios.clk_en) begin
      r_state <= w_next_state;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (w_op)
            OP_FILL:   w_next_state = ST_FILL;
            OP_WORD:   w_next_state = ST_WORD;
            OP_PIXEL:  w_next_state = ST_IDLE;
            OP_STATUS: w_next_state = ST_IDLE;
          endcase
        end
      end
      ST_FILL: if (r_idx == LAST_ADDR) w_next_state = ST_IDLE;
      ST_WORD: if (r_bit == 5'd31)     w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---- output / datapath next values ----
  always_comb begin
    w_wren      = 1'b0;
    w_done      = 1'b0;
    w_result    = '0;
    w_addr      = r_wraddr;
    w_data      = r_data;
    w_idx_n     = r_idx;
    w_bit_n     = r_bit;
    w_payload_n = r_payload;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (w_op)
            OP_PIXEL: begin
              w_wren = 1'b1;
              w_addr = w_cmd_addr;
              w_data = io_nios.datab[0];
              w_done = 1'b1;
            end
            OP_FILL: begin
              w_wren      = 1'b1;
              w_addr      = '0;
              w_data      = io_nios.datab[0];
              w_payload_n = io_nios.datab;
              w_idx_n     = ADDR_W'(1);
            end
            OP_WORD: begin
              w_wren      = 1'b1;
              w_addr      = word_base(w_cmd_addr);
              w_data      = io_nios.datab[0];
              w_payload_n = io_nios.datab;
              w_idx_n     = word_base(w_cmd_addr) + ADDR_W'(1);
              w_bit_n     = 5'd1;
            end
            OP_STATUS: begin
              w_done   = 1'b1;
              w_result = r_count;
            end
          endcase
        end
      end
      ST_FILL: begin
        w_wren  = 1'b1;
        w_addr  = r_idx;
        w_data  = r_payload[0];
        w_done  = (r_idx == LAST_ADDR);
        w_idx_n = r_idx + ADDR_W'(1);
      end
      ST_WORD: begin
        w_wren  = 1'b1;
        w_addr  = r_idx;
        w_data  = r_payload[r_bit];
        w_done  = (r_bit == 5'd31);
        w_idx_n = r_idx + ADDR_W'(1);
        w_bit_n = r_bit + 5'd1;
      end
      default: ;
    endcase
  end

  assign w_blk = w_done & (r_state != ST_IDLE);

  // ---- registered outputs and write counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wren   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_wraddr <= '0;
      r_data   <= 1'b0;
      r_count  <= '0;
      r_blk    <= 1'b0;
    end else if (io_nios.clk_en) begin
      r_wren   <= w_wren;
      r_done   <= w_done;
      r_result <= w_result;
      r_wraddr <= w_addr;
      r_data   <= w_data;
      r_count  <= r_count + 32'(w_wren);
      r_blk    <= w_blk;
    end
  end

  // Walk pointers and payload are only meaningful inside FILL/WORD.
  always_ff @(posedge clk) begin
    if (io_nios.clk_en) begin
      r_idx     <= w_idx_n;
      r_bit     <= w_bit_n;
      r_payload <= w_payload_n;
    end
  end

  assign io_nios.wren      = r_wren;
  assign io_nios.done      = r_done;
  assign io_nios.result    = r_result;
  assign io_nios.wraddress = r_wraddr;
  assign io_nios.data      = r_data;

endmodule

// File: tb/tb_image_ram_writer.sv
// Self-checking bench for image_ram_writer: command-level reference model
// producing the expected per-cycle output beats, plus directed literal checks.
module tb_image_ram_writer;
  import image_ram_writer_pkg::*;

  localparam int AW = IMG_ADDR_W;
  localparam int FRAME = 1 << AW;

  typedef struct packed {
    logic          wren;
    logic [AW-1:0] addr;
    logic          data;
    logic          done;
    logic [31:0]   result;
    logic          multi;
    logic          chk_ad;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_ram_writer_if bus_if ();

  image_ram_writer dut (
    .clk     (clk),
    .reset   (reset),
    .io_nios (bus_if)
  );

  int checks = 0;
  int failures = 0;

  beat_t q[$];
  beat_t exp_b;
  logic  ev_new = 1'b0;
  logic  seen = 1'b0;
  logic  blk = 1'b0;
  int    mcount = 0;
  int    n_wr = 0;
  int    n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: every command expands into its list of output beats.
  initial begin
    forever begin
      @(posedge clk);
      seen = 1'b1;
      if (reset) begin
        q.delete();
        mcount = 0;
        blk = 1'b0;
        exp_b = '{wren: 1'b0, addr: '0, data: 1'b0, done: 1'b0, result: '0, multi: 1'b0, chk_ad: 1'b1};
        ev_new = 1'b1;
      end else if (bus_if.clk_en) begin
        ev_new = 1'b1;
        if (q.size() == 0 && bus_if.start && !blk) begin
          logic [31:0]   a;
          logic [31:0]   b;
          logic [AW-1:0] base;
          a = bus_if.dataa;
          b = bus_if.datab;
          case (a[31:30])
            2'b00: q.push_back('{1'b1, a[AW-1:0], b[0], 1'b1, 32'd0, 1'b0, 1'b1});
            2'b01: for (int i = 0; i < FRAME; i++)
                     q.push_back('{1'b1, AW'(i), b[0], i == FRAME - 1, 32'd0, 1'b1, 1'b1});
            2'b10: begin
              base = a[AW-1:0] & ~AW'(31);
              for (int i = 0; i < 32; i++)
                q.push_back('{1'b1, base + AW'(i), b[i], i == 31, 32'd0, 1'b1, 1'b1});
            end
            default: q.push_back('{1'b0, AW'(0), 1'b0, 1'b1, 32'(mcount), 1'b0, 1'b0});
          endcase
        end
        if (q.size() > 0) exp_b = q.pop_front();
        else exp_b = '{wren: 1'b0, addr: '0, data: 1'b0, done: 1'b0, result: '0, multi: 1'b0, chk_ad: 1'b0};
        blk = exp_b.done && exp_b.multi;
        if (exp_b.wren) mcount++;
      end else begin
        ev_new = 1'b0;
      end
    end
  end

  // Compare process: new beats against the model, held beats against last sample.
  initial begin
    logic [31:0]   p_result;
    logic          p_done;
    logic          p_wren;
    logic          p_data;
    logic [AW-1:0] p_addr;
    forever begin
      @(negedge clk);
      if (seen) begin
        if (ev_new) begin
          chk("wren", 32'(bus_if.wren), 32'(exp_b.wren));
          chk("done", 32'(bus_if.done), 32'(exp_b.done));
          chk("result", bus_if.result, exp_b.result);
          if (exp_b.chk_ad) begin
            chk("wraddress", 32'(bus_if.wraddress), 32'(exp_b.addr));
            chk("data", 32'(bus_if.data), 32'(exp_b.data));
          end
          if (bus_if.wren === 1'b1) n_wr++;
          if (bus_if.done === 1'b1) n_done++;
        end else begin
          chk("hold_wren", 32'(bus_if.wren), 32'(p_wren));
          chk("hold_done", 32'(bus_if.done), 32'(p_done));
          chk("hold_result", bus_if.result, p_result);
          chk("hold_addr", 32'(bus_if.wraddress), 32'(p_addr));
          chk("hold_data", 32'(bus_if.data), 32'(p_data));
        end
      end
      p_result = bus_if.result;
      p_done   = bus_if.done;
      p_wren   = bus_if.wren;
      p_data   = bus_if.data;
      p_addr   = bus_if.wraddress;
    end
  end

  // Issue one command; returns at the negedge showing its first output beat.
  task automatic cmd(input logic [1:0] op, input int addr, input logic [31:0] b);
    bus_if.dataa  = {op, 18'd0, addr[11:0]};
    bus_if.datab  = b;
    bus_if.start  = 1'b1;
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.dataa  = $urandom;
    bus_if.datab  = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((q.size() != 0 || blk) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("wait_idle_timeout", 32'(q.size() != 0 || blk), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int base_wr;
    int base_done;
    int guard;
    logic [31:0] r;
    logic [31:0] rnd;

    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.clk_en = 1'b1;
    bus_if.dataa = '0;
    bus_if.datab = '0;
    repeat (3) @(negedge clk);
    chk("reset_wren", 32'(bus_if.wren), 32'd0);
    chk("reset_done", 32'(bus_if.done), 32'd0);
    chk("reset_result", bus_if.result, 32'd0);
    chk("reset_addr", 32'(bus_if.wraddress), 32'd0);
    chk("reset_data", 32'(bus_if.data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single pixel at x=5, y=2
    cmd(2'b00, (2 << 6) | 5, 32'd1);
    chk("pix_addr", 32'(bus_if.wraddress), 32'd133);
    chk("pix_data", 32'(bus_if.data), 32'd1);
    chk("pix_done", 32'(bus_if.done), 32'd1);
    chk("pix_result", bus_if.result, 32'd0);
    @(negedge clk);

    // Full-frame fill with zero
    base_wr = n_wr; base_done = n_done;
    cmd(2'b01, 77, 32'd0);
    wait_idle(6000);
    chk("fill_writes", 32'(n_wr - base_wr), 32'd4096);
    chk("fill_dones", 32'(n_done - base_done), 32'd1);
    cmd(2'b11, 0, 32'd0);
    chk("status_after_fill", bus_if.result, 32'd4097);
    @(negedge clk);

    // Word write at x=37, y=1 with a mid-command start that must be ignored
    base_done = n_done;
    cmd(2'b10, (1 << 6) | 37, 32'hA5A5_0001);
    chk("word_addr0", 32'(bus_if.wraddress), 32'd96);
    chk("word_data0", 32'(bus_if.data), 32'd1);
    @(negedge clk);
    chk("word_addr1", 32'(bus_if.wraddress), 32'd97);
    chk("word_data1", 32'(bus_if.data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom;
      bus_if.dataa = rnd;
      bus_if.start = 1'b1;
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    wait_idle(200);
    chk("word_dones", 32'(n_done - base_done), 32'd1);

    // Fill with clk_en low for 10 cycles mid-frame
    base_wr = n_wr;
    cmd(2'b01, 0, 32'd1);
    repeat (1000) @(negedge clk);
    bus_if.clk_en = 1'b0;
    repeat (10) @(negedge clk);
    bus_if.clk_en = 1'b1;
    wait_idle(6000);
    chk("stall_fill_writes", 32'(n_wr - base_wr), 32'd4096);
    cmd(2'b11, 0, 32'd0);
    chk("status_after_stall", bus_if.result, 32'd8225);
    @(negedge clk);

    // Reset in the middle of a fill
    base_wr = n_wr; base_done = n_done;
    cmd(2'b01, 0, 32'd1);
    guard = 0;
    while (n_wr - base_wr < 2000 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_2000_timeout", 32'(guard >= 5000), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_wren", 32'(bus_if.wren), 32'd0);
    chk("abort_done", 32'(bus_if.done), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_no_done", 32'(n_done - base_done), 32'd0);
    cmd(2'b11, 0, 32'd0);
    chk("status_after_reset", bus_if.result, 32'd0);
    @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 1499) == 0);
      bus_if.clk_en = ($urandom_range(0, 4) != 0);
      bus_if.start = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 99);
      rnd = $urandom;
      if (r < 1)       rnd[31:30] = 2'b01;
      else if (r < 40) rnd[31:30] = 2'b10;
      else if (r < 75) rnd[31:30] = 2'b00;
      else             rnd[31:30] = 2'b11;
      bus_if.dataa = rnd;
      bus_if.datab = $urandom;
      @(negedge clk);
    end
    reset = 1'b0;
    bus_if.start = 1'b0;
    bus_if.clk_en = 1'b1;
    wait_idle(6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
